// File: rtl/uart_tx_mmio_ctrl_pkg.sv
// uart_pkg: shared types and constants for the memory-mapped UART transmitter.
//   tx_state_e : serializer FSM states
//   REG_*      : register offsets, taken from dataadr[3:2]
//   ST_*       : bit positions inside the STATUS register
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_ACTIVE = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_OVF    = 3;

endpackage

// File: rtl/uart_tx_mmio_ctrl_if.sv
// CPU data-bus slice seen by the UART controller.
//   dataadr_i / writedata_i / memwrite_i : CPU -> peripheral
//   sel_o / readdata_o                   : peripheral -> CPU read mux
// master = CPU side, slave = peripheral side.
`timescale 1ns/1ps
interface uart_tx_mmio_ctrl_if;
  logic [31:0] dataadr_i;
  logic [31:0] writedata_i;
  logic        memwrite_i;
  logic        sel_o;
  logic [31:0] readdata_o;

  modport master (
    output dataadr_i, writedata_i, memwrite_i,
    input  sel_o, readdata_o
  );

  modport slave (
    input  dataadr_i, writedata_i, memwrite_i,
    output sel_o, readdata_o
  );
endinterface

// File: rtl/uart_tx_mmio_ctrl_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk_i, rst_i : clock, async active-low reset (pointers only)
//   push, din    : write request / data; accepted when not full, or when
//                  full and a pop happens in the same cycle
//   pop          : consume head (ignored while empty)
//   dout         : current head, valid whenever !empty
//   full, empty  : occupancy flags
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  // extra MSB distinguishes full from empty when the indices match
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // when full, the slot being written is the one popped this cycle
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/uart_tx_mmio_ctrl.sv
// uart_tx_mmio_ctrl: memory-mapped 8N1 UART transmitter with TX FIFO.
//   clk_i  : system clock
//   rst_i  : async active-low reset
//   bus    : CPU data bus slice (slave); sel_o flags the 16-byte window,
//            readdata_o is combinational register read data
//   tx_o   : serial line, idle high
//   busy_o : frame in progress or bytes still queued
// Registers (dataadr[3:2]): 0 TXDATA(W), 1 STATUS(R, W1C bit3),
// 2 CTRL(RW bit0 enable), 3 reserved.
`timescale 1ns/1ps
module uart_tx_mmio_ctrl
  import uart_pkg::*;
#(
  parameter int          CLK_FREQ   = 100_000_000,
  parameter int          BAUD       = 115_200,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_FF00,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  uart_tx_mmio_ctrl_if.slave   bus,
  output logic                 tx_o,
  output logic                 busy_o
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // decode
  logic       sel, wr;
  logic [1:0] off;
  assign sel = (bus.dataadr_i[31:4] == BASE_ADDR[31:4]);
  assign off = bus.dataadr_i[3:2];
  assign wr  = bus.memwrite_i && sel;

  logic unused_bits;
  assign unused_bits = &{1'b0, bus.dataadr_i[1:0], bus.writedata_i[31:8],
                         bus.writedata_i[7:4], bus.writedata_i[2:1]};

  // FIFO
  logic       push, pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  assign push = wr && (off == REG_TXDATA);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (bus.writedata_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // CTRL / overflow
  logic enable, overflow, ovf_set, ovf_clr;
  assign ovf_set = push && fifo_full && !pop;
  assign ovf_clr = wr && (off == REG_STATUS) && bus.writedata_i[3];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      enable   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr && (off == REG_CTRL)) enable <= bus.writedata_i[0];
      // a new overflow beats a simultaneous clear
      overflow <= ovf_set || (overflow && !ovf_clr);
    end
  end

  // serializer
  tx_state_e        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_done, tx_active;

  assign bit_done  = (baud_cnt == LAST_CNT);
  assign tx_active = (state != IDLE);
  // load from IDLE, or chain straight out of the last stop-bit cycle
  assign pop = enable && !fifo_empty &&
               ((state == IDLE) || ((state == STOP) && bit_done));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift <= fifo_dout;
            state <= START;
          end
        end
        START: begin
          if (bit_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else baud_cnt <= baud_cnt + CNT_ONE;
        end
        DATA: begin
          if (bit_done) begin
            baud_cnt <= '0;
            shift    <= shift >> 1;
            if (bit_idx == 3'd7) state <= STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else baud_cnt <= baud_cnt + CNT_ONE;
        end
        STOP: begin
          if (bit_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= fifo_dout;
              state <= START;
            end else state <= IDLE;
          end else baud_cnt <= baud_cnt + CNT_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // decoded from state so an async reset forces the line high at once
  always_comb begin
    tx_o = 1'b1;
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shift[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign busy_o = tx_active || !fifo_empty;

  // read mux
  logic [3:0] status;
  always_comb begin
    status            = '0;
    status[ST_ACTIVE] = tx_active;
    status[ST_EMPTY]  = fifo_empty;
    status[ST_FULL]   = fifo_full;
    status[ST_OVF]    = overflow;
  end

  always_comb begin
    bus.readdata_o = '0;
    if (sel) begin
      case (off)
        REG_STATUS: bus.readdata_o = {28'b0, status};
        REG_CTRL:   bus.readdata_o = {31'b0, enable};
        default:    bus.readdata_o = '0;
      endcase
    end
  end

  assign bus.sel_o = sel;
endmodule

// File: tb/tb_uart_tx_mmio_ctrl.sv
`timescale 1ns/1ps
module tb_uart_tx_mmio_ctrl;
  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_CT = BASE + 32'h8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, busy;
  always #5 clk = ~clk;

  uart_tx_mmio_ctrl_if bus();

  uart_tx_mmio_ctrl #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .BASE_ADDR(BASE), .FIFO_DEPTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bus), .tx_o(tx), .busy_o(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  int starts[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // line receiver: cycle 0 = first low sample, bits sampled mid-cell
  logic       mon_busy = 1'b0;
  int         mon_cyc = 0;
  logic [7:0] rx_byte = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy <= 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy <= 1'b1;
        mon_cyc  <= 1;
        starts.push_back(cyc);
      end
    end else begin
      mon_cyc <= mon_cyc + 1;
      if (mon_cyc == 5) chk("start_bit", {31'b0, tx}, 32'd0);
      if (mon_cyc >= 15 && mon_cyc <= 85 && (mon_cyc % 10) == 5)
        rx_byte <= {tx, rx_byte[7:1]};
      if (mon_cyc == 95) begin
        chk("stop_bit", {31'b0, tx}, 32'd1);
        if (sb.size() == 0) chk("rx_unexpected", {24'b0, rx_byte}, 32'hFFFF_FFFF);
        else chk("rx_byte", {24'b0, rx_byte}, {24'b0, sb.pop_front()});
      end
      if (mon_cyc == 99) mon_busy <= 1'b0;
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.dataadr_i   = a;
    bus.writedata_i = d;
    bus.memwrite_i  = 1'b1;
    @(posedge clk); #1;
    bus.memwrite_i  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
    bus.dataadr_i  = a;
    bus.memwrite_i = 1'b0;
    #1;
    d = bus.readdata_o;
    s = bus.sel_o;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while ((busy || mon_busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) chk(tag, 32'd1, 32'd0);
  endtask

  logic [31:0] d;
  logic        s;
  int          lat, n0;

  initial begin
    bus.dataadr_i = '0; bus.writedata_i = '0; bus.memwrite_i = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    rd(A_ST, d, s); chk("rst_status", d, 32'h2);
    rd(A_CT, d, s); chk("rst_ctrl", d, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single byte, latency and frame length
    wr(A_CT, 32'h1);
    rd(A_CT, d, s); chk("ctrl_rb", d, 32'h1);
    sb.push_back(8'h55);
    wr(A_TX, 32'h55);
    lat = 0;
    do begin @(negedge clk); lat++; end while (tx !== 1'b0 && lat < 20);
    chk("start_lat", lat, 2);
    rd(A_ST, d, s); chk("status_active", d, 32'h3);
    lat = 0;
    do begin @(negedge clk); lat++; end while (busy && lat < 300);
    chk("busy_fall", lat, 100);
    wait_idle("single_timeout", 200);

    // overflow, then contiguous drain
    wr(A_CT, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) sb.push_back(8'(i));
      wr(A_TX, i);
    end
    rd(A_ST, d, s); chk("status_ovf", d, 32'hC);
    n0 = starts.size();
    wr(A_CT, 32'h1);
    wait_idle("drain_timeout", 1500);
    chk("drain_frames", starts.size() - n0, 8);
    for (int k = 1; k < 8; k++)
      if (n0 + k < starts.size()) chk("frame_gap", starts[n0+k] - starts[n0+k-1], 100);
    rd(A_ST, d, s); chk("status_drained", d, 32'hA);
    wr(A_ST, 32'h8);
    rd(A_ST, d, s); chk("status_w1c", d, 32'h2);

    // enable dropped mid-frame with one byte still queued
    n0 = starts.size();
    sb.push_back(8'hA1); sb.push_back(8'h3E);
    wr(A_TX, 32'hA1);
    wr(A_TX, 32'h3E);
    repeat (35) @(negedge clk);
    wr(A_CT, 32'h0);
    repeat (150) @(negedge clk);
    chk("dis_tx", {31'b0, tx}, 32'd1);
    rd(A_ST, d, s); chk("dis_status", d, 32'h0);
    chk("dis_frames", starts.size() - n0, 1);
    wr(A_CT, 32'h1);
    wait_idle("reen_timeout", 300);
    chk("reen_frames", starts.size() - n0, 2);

    // reset during DATA bit 3
    sb.push_back(8'h3C);
    wr(A_TX, 32'h3C);
    repeat (45) @(negedge clk);
    n0 = starts.size();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", {31'b0, tx}, 32'd1);
    sb.delete();
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    rd(A_ST, d, s); chk("rst_mid_status", d, 32'h2);
    repeat (200) @(negedge clk);
    chk("rst_mid_frames", starts.size() - n0, 0);

    // decode window
    wr(A_CT, 32'h1);
    rd(BASE + 32'h10, d, s); chk("sel_out", {31'b0, s}, 32'd0);
    rd(BASE + 32'hC, d, s);  chk("sel_rsvd", {31'b0, s}, 32'd1);
    chk("rsvd_rd", d, 32'h0);
    rd(BASE + 32'h5, d, s);  chk("lowbits_ign", d, 32'h2);
    rd(A_TX, d, s);          chk("txdata_rd", d, 32'h0);
    n0 = starts.size();
    wr(BASE + 32'h10, 32'hAA);
    wr(BASE + 32'hC, 32'hAA);
    repeat (150) @(negedge clk);
    chk("decode_frames", starts.size() - n0, 0);
    rd(A_ST, d, s); chk("decode_status", d, 32'h2);
    chk("sb_left", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
